test_ram_slave: RTL and testbench

Bus responder for the skeleton interconnect's test RAM window. It decodes accesses at TEST_RAM_OFFSET..TEST_RAM_OFFSET+TEST_RAM_SIZE-1, performs single-word reads and writes to an internal 256-word synchronous RAM, and answers each request with a four-phase acknowledge. It sits on one slave port of the master/slave skeleton fabric and is the responder counterpart to the bus master.

---
 rtl/test_ram_slave_pkg.sv | 24 ++
 rtl/test_ram_mem.sv | 34 +++
 rtl/test_ram_slave.sv | 168 ++++++++++++++++
 tb/tb_test_ram_slave.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/test_ram_slave_pkg.sv
// -----------------------------------------------------------------------------
// test_ram_slave_pkg
// Shared constants and types for the skeleton interconnect's test RAM window.
//   TEST_RAM_OFFSET / TEST_RAM_SIZE : decoded address window
//   BUS_ADDR_W / BUS_DATA_W         : bus widths
//   TEST_RAM_WAIT_STATES            : default wait states before acknowledge
//   test_ram_state_t                : responder FSM states
// No ports (package).
// -----------------------------------------------------------------------------
package test_ram_slave_pkg;

    localparam int unsigned TEST_RAM_OFFSET      = 4096;
    localparam int unsigned TEST_RAM_SIZE        = 256;
    localparam int unsigned BUS_ADDR_W           = 16;
    localparam int unsigned BUS_DATA_W           = 16;
    localparam int unsigned TEST_RAM_WAIT_STATES = 0;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } test_ram_state_t;

endpackage

// File: rtl/test_ram_mem.sv
// -----------------------------------------------------------------------------
// test_ram_mem
// Single-port synchronous RAM with a registered read port. Contents are not
// reset. The read port samples every cycle, so dout always reflects the word
// addressed on the previous edge (read-before-write on a colliding write).
// Ports:
//   clk  in  1      clock
//   we   in  1      write enable
//   addr in  AW     word index
//   din  in  WIDTH  write data
//   dout out WIDTH  registered read data
// -----------------------------------------------------------------------------
module test_ram_mem #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/test_ram_slave.sv
// -----------------------------------------------------------------------------
// test_ram_slave
// Bus responder for the test RAM window [BASE, BASE+DEPTH). Single-word reads
// and writes with a four-phase acknowledge and WAIT_STATES extra cycles.
// Optional feature macro: TEST_RAM_PARITY_EN (even parity per word, bus_perr).
// Ports:
//   clk       in  1       system clock
//   rst_n     in  1       asynchronous active-low reset
//   bus_addr  in  ADDR_W  word address
//   bus_wdata in  DATA_W  write data
//   bus_wr    in  1       write request level
//   bus_rd    in  1       read request level (bus_wr wins if both high)
//   bus_rdata out DATA_W  last completed read data
//   bus_ack   out 1       acknowledge level
//   bus_hit   out 1       combinational window decode
//   bus_perr  out 1       parity error on last read (TEST_RAM_PARITY_EN only)
// -----------------------------------------------------------------------------
module test_ram_slave
    import test_ram_slave_pkg::*;
#(
    parameter int unsigned ADDR_W      = BUS_ADDR_W,
    parameter int unsigned DATA_W      = BUS_DATA_W,
    parameter int unsigned BASE        = TEST_RAM_OFFSET,
    parameter int unsigned DEPTH       = TEST_RAM_SIZE,
    parameter int unsigned WAIT_STATES = TEST_RAM_WAIT_STATES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_wr,
    input  logic              bus_rd,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              bus_ack,
`ifdef TEST_RAM_PARITY_EN
    output logic              bus_perr,
`endif
    output logic              bus_hit
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
`ifdef TEST_RAM_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif

    // Window bounds one bit wider than the bus so BASE+DEPTH cannot wrap.
    localparam logic [ADDR_W:0] WIN_LO    = (ADDR_W+1)'(BASE);
    localparam logic [ADDR_W:0] WIN_HI    = (ADDR_W+1)'(BASE + DEPTH);
    localparam logic [3:0]      WAIT_LAST = 4'(WAIT_STATES);

    test_ram_state_t   state, state_d;
    logic [3:0]        cnt;
    logic [IDX_W-1:0]  addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              op_wr_q;
    logic              req;
    logic              capture;
    logic              complete;
    logic [ADDR_W:0]   addr_ext;
    logic [IDX_W-1:0]  bus_idx;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_addr;
    logic [MEM_W-1:0]  mem_din;
    logic [MEM_W-1:0]  mem_dout;

    assign req      = bus_wr | bus_rd;
    assign addr_ext = {1'b0, bus_addr};
    assign bus_hit  = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
    assign bus_idx  = IDX_W'(bus_addr - ADDR_W'(BASE));
    assign bus_ack  = (state == ACK);

    always_comb begin
        state_d  = state;
        capture  = 1'b0;
        complete = 1'b0;
        case (state)
            IDLE: begin
                if (req && bus_hit) begin
                    capture = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (cnt == WAIT_LAST) begin
                    complete = 1'b1;
                    state_d  = ACK;
                end
            end
            ACK: begin
                if (!req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_wr_q <= 1'b0;
        end else if (capture) begin
            cnt     <= '0;
            addr_q  <= bus_idx;
            wdata_q <= bus_wdata;
            op_wr_q <= bus_wr;
        end else if (state == ACCESS) begin
            cnt <= cnt + 4'd1;
        end
    end

    // The RAM read port follows the live bus index while idle so the word is
    // already in mem_dout one edge after capture, giving zero-wait reads.
    assign mem_we   = complete && op_wr_q;
    assign mem_addr = (state == IDLE) ? bus_idx : addr_q;
`ifdef TEST_RAM_PARITY_EN
    assign mem_din  = {^wdata_q, wdata_q};
`else
    assign mem_din  = wdata_q;
`endif

    test_ram_mem #(
        .WIDTH (MEM_W),
        .DEPTH (DEPTH),
        .AW    (IDX_W)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .addr (mem_addr),
        .din  (mem_din),
        .dout (mem_dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_rdata <= '0;
        end else if (complete && !op_wr_q) begin
            bus_rdata <= mem_dout[DATA_W-1:0];
        end
    end

`ifdef TEST_RAM_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_perr <= 1'b0;
        end else if (capture) begin
            bus_perr <= 1'b0;
        end else if (complete && !op_wr_q) begin
            bus_perr <= ^mem_dout;
        end
    end
`endif

endmodule

// File: tb/tb_test_ram_slave.sv
// -----------------------------------------------------------------------------
// tb_test_ram_slave
// Two responders share one set of bus inputs: dut0 with WAIT_STATES=0 and
// dut3 with WAIT_STATES=3. Each transaction holds the request until both have
// acknowledged, so their RAM contents stay identical except where a sequence
// deliberately diverges them (abort, reset mid-write).
// Optional feature macro: TEST_RAM_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_test_ram_slave;
    import test_ram_slave_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_wr;
    logic        bus_rd;
    logic [15:0] rdata0, rdata3;
    logic        ack0, ack3, hit0, hit3;
`ifdef TEST_RAM_PARITY_EN
    logic        perr0, perr3;
`endif

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    test_ram_slave #(.WAIT_STATES(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_wr    (bus_wr),
        .bus_rd    (bus_rd),
        .bus_rdata (rdata0),
        .bus_ack   (ack0),
`ifdef TEST_RAM_PARITY_EN
        .bus_perr  (perr0),
`endif
        .bus_hit   (hit0)
    );

    test_ram_slave #(.WAIT_STATES(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_wr    (bus_wr),
        .bus_rd    (bus_rd),
        .bus_rdata (rdata3),
        .bus_ack   (ack3),
`ifdef TEST_RAM_PARITY_EN
        .bus_perr  (perr3),
`endif
        .bus_hit   (hit3)
    );

    typedef struct {
        string       name;
        logic        wr;
        logic        rd;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        exp_hit;
        logic [15:0] exp_rdata0;
        logic [15:0] exp_rdata3;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request and hold it until both responders ack (or a
    // 24-edge budget runs out), then release and check the ack drops.
    task automatic xact(input string name, input logic wr, input logic rd,
                        input logic [15:0] addr, input logic [15:0] wdata,
                        input logic exp_hit, input logic [15:0] e0, input logic [15:0] e3);
        int lat0 = -1;
        int lat3 = -1;
        bus_wr    = wr;
        bus_rd    = rd;
        bus_addr  = addr;
        bus_wdata = wdata;
        #1;
        check({name, " hit0"}, 32'(hit0), 32'(exp_hit));
        check({name, " hit3"}, 32'(hit3), 32'(exp_hit));
        for (int e = 0; e < 24; e++) begin
            tick();
            if (lat0 < 0 && ack0) lat0 = e;
            if (lat3 < 0 && ack3) lat3 = e;
            if (lat0 >= 0 && lat3 >= 0) break;
        end
        check({name, " ack latency dut0"}, 32'(lat0), exp_hit ? 32'd1 : 32'hFFFF_FFFF);
        check({name, " ack latency dut3"}, 32'(lat3), exp_hit ? 32'd4 : 32'hFFFF_FFFF);
        check({name, " rdata dut0"}, 32'(rdata0), 32'(e0));
        check({name, " rdata dut3"}, 32'(rdata3), 32'(e3));
        bus_wr = 1'b0;
        bus_rd = 1'b0;
        tick();
        check({name, " ack released"}, {30'd0, ack0, ack3}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{"wr 4099",      1, 0, 16'd4099, 16'hA5A5, 1, 16'h0000, 16'h0000};
        tbl[1]  = '{"rd 4099",      0, 1, 16'd4099, 16'h0000, 1, 16'hA5A5, 16'hA5A5};
        tbl[2]  = '{"wr 4351",      1, 0, 16'd4351, 16'h1234, 1, 16'hA5A5, 16'hA5A5};
        tbl[3]  = '{"rd 4351",      0, 1, 16'd4351, 16'h0000, 1, 16'h1234, 16'h1234};
        tbl[4]  = '{"rd 4095 miss", 0, 1, 16'd4095, 16'h0000, 0, 16'h1234, 16'h1234};
        tbl[5]  = '{"rd 4352 miss", 0, 1, 16'd4352, 16'h0000, 0, 16'h1234, 16'h1234};
        tbl[6]  = '{"wr+rd 4200",   1, 1, 16'd4200, 16'h00FF, 1, 16'h1234, 16'h1234};
        tbl[7]  = '{"rd 4200",      0, 1, 16'd4200, 16'h0000, 1, 16'h00FF, 16'h00FF};
        tbl[8]  = '{"wr 4100",      1, 0, 16'd4100, 16'h5555, 1, 16'h00FF, 16'h00FF};
        tbl[9]  = '{"wr 4101",      1, 0, 16'd4101, 16'h1111, 1, 16'h00FF, 16'h00FF};
        tbl[10] = '{"rd 4100",      0, 1, 16'd4100, 16'h0000, 1, 16'h5555, 16'h5555};

        // Reset held with a live read request at the window base.
        rst_n     = 1'b0;
        bus_addr  = 16'd4096;
        bus_wdata = '0;
        bus_wr    = 1'b0;
        bus_rd    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("reset ack", {30'd0, ack0, ack3}, 32'd0);
            check("reset rdata", {rdata0, rdata3}, 32'd0);
        end
        bus_rd = 1'b0;
        rst_n  = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            xact(tbl[i].name, tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wdata,
                 tbl[i].exp_hit, tbl[i].exp_rdata0, tbl[i].exp_rdata3);
        end

        // Write dropped after edge 2: dut0 already completed it, dut3 aborts.
        bus_addr  = 16'd4100;
        bus_wdata = 16'hBEEF;
        bus_wr    = 1'b1;
        for (int e = 0; e < 3; e++) begin
            tick();
            check("abort dut3 no ack", 32'(ack3), 32'd0);
        end
        check("abort dut0 acked", 32'(ack0), 32'd1);
        bus_wr = 1'b0;
        for (int e = 0; e < 4; e++) begin
            tick();
            check("abort idle ack", {30'd0, ack0, ack3}, 32'd0);
        end
        xact("rd 4100 after abort", 0, 1, 16'd4100, 16'h0000, 1, 16'hBEEF, 16'h5555);

        // Asynchronous reset between capture and dut3's write.
        bus_addr  = 16'd4101;
        bus_wdata = 16'h7777;
        bus_wr    = 1'b1;
        tick();
        tick();
        check("pre-reset dut0 ack", 32'(ack0), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid reset ack", {30'd0, ack0, ack3}, 32'd0);
        check("mid reset rdata", {rdata0, rdata3}, 32'd0);
        bus_wr = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        xact("rd 4101 after reset", 0, 1, 16'd4101, 16'h0000, 1, 16'h7777, 16'h1111);

`ifdef TEST_RAM_PARITY_EN
        check("perr clear", {30'd0, perr0, perr3}, 32'd0);
        dut0.u_mem.mem[5][0] = ~dut0.u_mem.mem[5][0];
        xact("rd 4101 flipped", 0, 1, 16'd4101, 16'h0000, 1, 16'h7776, 16'h1111);
        check("perr dut0 set", 32'(perr0), 32'd1);
        check("perr dut3 clean", 32'(perr3), 32'd0);
        xact("rd 4099 after perr", 0, 1, 16'd4099, 16'h0000, 1, 16'hA5A5, 16'hA5A5);
        check("perr dut0 cleared", 32'(perr0), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
